armored66_tx_sched: RTL
=======================

Name: armored66_tx_sched

Overview:
- Word scheduler placed in front of the armored66 TX datapath, in the din_clk domain.
- On every din_phase slot it chooses one NUM_LN*66-bit word for the transmitter: a periodic or forced flow-control word, buffered user data, or an idle word.
- It replaces ad-hoc traffic/flow-control muxing with a registered, arbitrated source, and keeps per-kind transmit counters for link bring-up.

Parameters:
NUM_LN, 4, lanes; word width is NUM_LN*66
FC_PERIOD, 100, slots per flow-control period (2..65535)
FC_SLOT, 50, slot index within the period at which the periodic FC word is sent (0..FC_PERIOD-1)

Ports:
clk  in  1  din_clk from armored66_tx
arst  in  1  asynchronous active-high reset
din_phase  in  1  slot strobe; dout is consumed by TX on cycles where this is 1
enable  in  1  0 = send idles only
fc_byte  in  8  flow-control credit byte, sampled when an FC word is selected
fc_force  in  1  pulse; requests an extra FC word at the next slot
s_data  in  NUM_LN*66  user word (per-lane sync header included)
s_valid  in  1  user word valid
s_ready  out  1  scheduler can accept s_data
dout  out  NUM_LN*66  registered word to armored66_tx din
dout_kind  out  2  kind of the current dout: 0 idle, 1 data, 2 FC
cnt_data  out  32  data words sent, wraps
cnt_fc  out  32  FC words sent, wraps
cnt_idle  out  32  idle words sent, wraps

Behaviour:
- Word formats, each replicated NUM_LN times from MSB down:
  - FC lane = {fc_byte, 20'b0, 4'b1100, 32'h0, 2'b01}
  - Idle lane = {8'h00, 20'b0, 4'b0000, 32'h0, 2'b01}
- Reset (arst high, async):
  - dout = 0, dout_kind = 0, all counters = 0.
  - Slot counter = 0, force flag = 0, FIFO empty, s_ready = 0 while arst is asserted.
  - Reset mid-operation discards FIFO contents and any pending force.
- Input FIFO:
  - 2 entries. s_ready = !full, registered, and never depends on s_valid.
  - Push when s_valid & s_ready. Push and pop may coincide when the FIFO is non-full; occupancy is then unchanged.
  - When full, s_ready is 0. If a pop occurs, s_ready returns to 1 on the next cycle.
- Force flag:
  - Set by fc_force; cleared when an FC word is selected.
  - If fc_force and an FC selection occur in the same cycle, the flag ends at 0, because the request is satisfied by that FC word.
- Slot counter:
  - Counts 0..FC_PERIOD-1 and increments on each din_phase with enable=1.
  - Wraps from FC_PERIOD-1 to 0.
  - While enable=0 it holds its value.
- On din_phase=1 the scheduler selects, in priority order:
  - FC if enable & (slot counter==FC_SLOT | force flag);
  - else data if enable & FIFO non-empty (pop head);
  - else idle.
- dout and dout_kind are updated one cycle after the selecting din_phase.
- dout holds its value on cycles with din_phase=0.
- The counter matching the selected kind increments once per slot, wrapping at 2^32.
- A periodic FC slot that coincides with a pending force sends one FC word; it clears the force and counts once.
- Data latency: a word accepted at cycle t is eligible at the first din_phase at t+1 or later. It is output in the cycle after that slot, unless the slot goes to FC.
- Data order is strictly preserved; FC words only delay data.
- enable=0: every slot is idle. Buffered data and the force flag are retained. After enable rises, scheduling resumes from the held slot count.

Test Plan:
- Reset then enable=1, no s_valid, din_phase every 2nd cycle for 200 slots → FC at slots 50 and 150 with dout lane = {8'hff,...,2'b01} when fc_byte=8'hff. cnt_fc=2, cnt_idle=198, cnt_data=0.
- Push 3 words back-to-back with din_phase held low → s_ready drops after 2 accepts and the third word stays held. Raise din_phase → data emitted in push order, s_ready returns to 1.
- Data word queued for slot 50 → slot 50 emits FC (dout_kind=2), queued word emitted at slot 51. cnt_data increments by 1, no word lost.
- fc_force pulse at slot 10, plus fc_force asserted in the same cycle as the slot-50 selection → FC at slots 11 and 50 only. Force flag reads 0 after slot 50.
- enable=0 at slot 30 for 20 slots with 2 words queued → 20 idles sent. FC appears at slot 50 of the resumed count, and queued data is intact after enable returns.
- arst asserted mid-stream with FIFO full → dout=0 and counters=0 immediately. After release the first slot emits idle with no stale data.

Source files
------------

// File: rtl/armored66_tx_sched.sv
// armored66_tx_sched: per-slot word scheduler in front of the armored66 TX datapath.
// Picks FC (periodic or forced), buffered user data, or idle on every din_phase slot,
// registers the chosen word and keeps per-kind transmit counters.

// Per-lane word formatter: builds one 66-bit lane for the selected kind.
module armored66_tx_sched_lane (
  input  logic [1:0]  kind,
  input  logic [7:0]  fc_byte,
  input  logic [65:0] data,
  output logic [65:0] word
);
  localparam logic [1:0] KIND_DATA = 2'd1;
  localparam logic [1:0] KIND_FC   = 2'd2;

  // Lane format mux; idle is the default so an unknown kind never leaks data.
  always_comb begin
    word = {8'h00, 20'b0, 4'b0000, 32'h0, 2'b01};
    case (kind)
      KIND_DATA: word = data;
      KIND_FC:   word = {fc_byte, 20'b0, 4'b1100, 32'h0, 2'b01};
      default:   word = {8'h00, 20'b0, 4'b0000, 32'h0, 2'b01};
    endcase
  end
endmodule

module armored66_tx_sched #(
  parameter int NUM_LN    = 4,
  parameter int FC_PERIOD = 100,
  parameter int FC_SLOT   = 50
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 din_phase,
  input  logic                 enable,
  input  logic [7:0]           fc_byte,
  input  logic                 fc_force,
  input  logic [NUM_LN*66-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [NUM_LN*66-1:0] dout,
  output logic [1:0]           dout_kind,
  output logic [31:0]          cnt_data,
  output logic [31:0]          cnt_fc,
  output logic [31:0]          cnt_idle
);
  localparam int         W         = NUM_LN * 66;
  localparam logic [1:0] KIND_IDLE = 2'd0;
  localparam logic [1:0] KIND_DATA = 2'd1;
  localparam logic [1:0] KIND_FC   = 2'd2;
  localparam logic [15:0] SLOT_FC   = 16'(FC_SLOT);
  localparam logic [15:0] SLOT_LAST = 16'(FC_PERIOD - 1);

  // Scheduler state
  logic [15:0] slot_cnt;
  logic        force_q;

  // 2-entry input FIFO
  logic [W-1:0] fifo_mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   fifo_cnt, fifo_cnt_nxt;
  logic         s_ready_q;

  // Selection
  logic [1:0]  sel_kind;
  logic        push, pop, fc_sel;

  logic [NUM_LN-1:0][65:0] head_ln;
  logic [NUM_LN-1:0][65:0] word_ln;

  assign s_ready = s_ready_q;
  assign head_ln = fifo_mem[rd_ptr];

  // Priority pick for the current slot: FC, then FIFO head, then idle.
  always_comb begin
    sel_kind = KIND_IDLE;
    if (enable && (slot_cnt == SLOT_FC || force_q))
      sel_kind = KIND_FC;
    else if (enable && fifo_cnt != 2'd0)
      sel_kind = KIND_DATA;
  end

  assign push   = s_valid && s_ready_q;
  assign pop    = din_phase && (sel_kind == KIND_DATA);
  assign fc_sel = din_phase && (sel_kind == KIND_FC);

  // Occupancy after this cycle's push/pop; s_ready is registered from it.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop)      fifo_cnt_nxt = fifo_cnt + 2'd1;
    else if (!push && pop) fifo_cnt_nxt = fifo_cnt - 2'd1;
  end

  // FIFO storage; pointers carry validity so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt  <= fifo_cnt_nxt;
      s_ready_q <= (fifo_cnt_nxt != 2'd2);
    end
  end

  // Slot counter advances only on enabled slots, so a disabled stretch is invisible to the FC period.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      slot_cnt <= 16'd0;
    else if (din_phase && enable)
      slot_cnt <= (slot_cnt == SLOT_LAST) ? 16'd0 : slot_cnt + 16'd1;
  end

  // Force request: an FC selection in the same cycle satisfies a coincident fc_force.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) force_q <= 1'b0;
    else      force_q <= (force_q || fc_force) && !fc_sel;
  end

  for (genvar g = 0; g < NUM_LN; g++) begin : g_lane
    armored66_tx_sched_lane u_lane (
      .kind    (sel_kind),
      .fc_byte (fc_byte),
      .data    (head_ln[g]),
      .word    (word_ln[g])
    );
  end

  // Output word register and per-kind counters, updated only on slots.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dout      <= '0;
      dout_kind <= KIND_IDLE;
      cnt_data  <= 32'd0;
      cnt_fc    <= 32'd0;
      cnt_idle  <= 32'd0;
    end else if (din_phase) begin
      dout      <= word_ln;
      dout_kind <= sel_kind;
      case (sel_kind)
        KIND_DATA: cnt_data <= cnt_data + 32'd1;
        KIND_FC:   cnt_fc   <= cnt_fc + 32'd1;
        default:   cnt_idle <= cnt_idle + 32'd1;
      endcase
    end
  end
endmodule
